// File: rtl/music_play_ctrl.sv
// music_play_ctrl: sequencer between the alarm/key FSM and the music-player
// datapath. Loads the song base into the address counter, fetches each note
// word from the synchronous ROM, plays it for one beat with a silent
// articulation gap, then steps the counter. Stops at the end marker, loops
// when LOOP_EN is set, and a watchdog caps the number of entries per pass.
module music_play_ctrl #(
    parameter int MSC_N     = 5,
    parameter int BEAT_CYC  = 12500000,
    parameter int GAP_CYC   = 1250000,
    parameter int MAX_NOTES = 1023,
    parameter int LOOP_EN   = 0
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic [MSC_N-1:0] play_req,
    input  logic             stop,
    input  logic             pause,
    input  logic [7:0]       rom_data,
    output logic [MSC_N-1:0] sel,
    output logic             add,
    output logic [6:0]       note,
    output logic             note_vld,
    output logic             busy,
    output logic [MSC_N-1:0] song_id
);

    localparam int BW = $clog2(BEAT_CYC + 1);
    localparam int NW = $clog2(MAX_NOTES + 1);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYC - 1);
    localparam logic [BW-1:0] VLD_END   = BW'(BEAT_CYC - GAP_CYC);
    localparam logic [NW-1:0] NOTE_MAX  = NW'(MAX_NOTES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH1,
        FETCH2,
        PLAY,
        ADV
    } state_t;

    state_t          state_reg;
    logic [BW-1:0]   beat_cnt_reg;
    logic [NW-1:0]   note_cnt_reg;
    logic [6:0]      note_lat_reg;

    logic [MSC_N:0]   req_seen;
    logic [MSC_N-1:0] req_first;
    logic             req_any;
    logic [6:0]       rom_code;
    logic [BW-1:0]    beat_nxt;

    // Priority pick: a request bit wins only if no lower-index bit is set.
    assign req_seen[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < MSC_N; gi++) begin : g_prio
            assign req_first[gi]  = play_req[gi] & ~req_seen[gi];
            assign req_seen[gi+1] = req_seen[gi] | play_req[gi];
        end
    endgenerate
    assign req_any = req_seen[MSC_N];

    // Words with bit7 set (other than the end marker) are rests.
    assign rom_code = rom_data[7] ? 7'd0 : rom_data[6:0];
    assign beat_nxt = beat_cnt_reg + BW'(1);

    // Sequencer FSM; every output is a register loaded for the next state.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            note_cnt_reg <= '0;
            note_lat_reg <= '0;
            sel          <= '0;
            add          <= 1'b0;
            note         <= '0;
            note_vld     <= 1'b0;
            busy         <= 1'b0;
            song_id      <= '0;
        end else begin
            // Load/increment strobes are single-cycle unless re-armed below.
            sel <= '0;
            add <= 1'b0;
            if (state_reg != IDLE && stop) begin
                state_reg <= IDLE;
                note      <= '0;
                note_vld  <= 1'b0;
                busy      <= 1'b0;
                song_id   <= '0;
            end else if (req_any && state_reg != LOAD) begin
                // New request (or preemption); ignored during LOAD so sel
                // can never stay high for two consecutive cycles.
                state_reg <= LOAD;
                song_id   <= req_first;
                sel       <= req_first;
                busy      <= 1'b1;
                note      <= '0;
                note_vld  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= IDLE;
                    end
                    LOAD: begin
                        note_cnt_reg <= '0;
                        state_reg    <= FETCH1;
                    end
                    FETCH1: begin
                        state_reg <= FETCH2;
                    end
                    FETCH2: begin
                        if (rom_data == 8'hFF) begin
                            if (LOOP_EN != 0) begin
                                state_reg <= LOAD;
                                sel       <= song_id;
                            end else begin
                                state_reg <= IDLE;
                                busy      <= 1'b0;
                                song_id   <= '0;
                            end
                        end else begin
                            note_lat_reg <= rom_code;
                            note_cnt_reg <= note_cnt_reg + NW'(1);
                            beat_cnt_reg <= '0;
                            note         <= rom_code;
                            note_vld     <= (rom_code != 7'd0);
                            state_reg    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (pause) begin
                            note     <= '0;
                            note_vld <= 1'b0;
                        end else if (beat_cnt_reg == BEAT_LAST) begin
                            note      <= '0;
                            note_vld  <= 1'b0;
                            add       <= (note_cnt_reg != NOTE_MAX);
                            state_reg <= ADV;
                        end else begin
                            beat_cnt_reg <= beat_nxt;
                            if (beat_nxt < VLD_END && note_lat_reg != 7'd0) begin
                                note     <= note_lat_reg;
                                note_vld <= 1'b1;
                            end else begin
                                note     <= '0;
                                note_vld <= 1'b0;
                            end
                        end
                    end
                    ADV: begin
                        if (note_cnt_reg == NOTE_MAX) begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                            song_id   <= '0;
                        end else begin
                            state_reg <= FETCH1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        song_id   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_play_ctrl.sv
// Bench for music_play_ctrl: one stopping/watchdog instance (A) and one
// looping instance (B), each driving its own address-counter + ROM model.
module tb_music_play_ctrl;

    localparam int MSC_N = 5;
    localparam int BEAT  = 8;
    localparam int GAP   = 2;
    localparam int MAXN  = 4;

    logic             sysclk = 1'b0;
    logic             rst_n  = 1'b0;
    logic [MSC_N-1:0] play_req = '0;
    logic             stop  = 1'b0;
    logic             pause = 1'b0;

    logic [7:0]       rom_a, rom_b;
    logic [MSC_N-1:0] sel_a, sel_b, sid_a, sid_b;
    logic             add_a, add_b, vld_a, vld_b, busy_a, busy_b;
    logic [6:0]       note_a, note_b;
    logic [19:0]      out_a, out_b;

    logic [7:0] rom_mem [0:63];
    logic [5:0] addr_a = '0;
    logic [5:0] addr_b = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 sysclk = ~sysclk;

    music_play_ctrl #(.MSC_N(MSC_N), .BEAT_CYC(BEAT), .GAP_CYC(GAP),
                      .MAX_NOTES(MAXN), .LOOP_EN(0)) dut_a (
        .sysclk(sysclk), .rst_n(rst_n), .play_req(play_req), .stop(stop),
        .pause(pause), .rom_data(rom_a), .sel(sel_a), .add(add_a),
        .note(note_a), .note_vld(vld_a), .busy(busy_a), .song_id(sid_a));

    music_play_ctrl #(.MSC_N(MSC_N), .BEAT_CYC(BEAT), .GAP_CYC(GAP),
                      .MAX_NOTES(MAXN), .LOOP_EN(1)) dut_b (
        .sysclk(sysclk), .rst_n(rst_n), .play_req(play_req), .stop(stop),
        .pause(pause), .rom_data(rom_b), .sel(sel_b), .add(add_b),
        .note(note_b), .note_vld(vld_b), .busy(busy_b), .song_id(sid_b));

    assign out_a = {sel_a, add_a, note_a, vld_a, busy_a, sid_a};
    assign out_b = {sel_b, add_b, note_b, vld_b, busy_b, sid_b};

    // Song s starts at ROM address 8*s.
    function automatic logic [5:0] base_of(input logic [MSC_N-1:0] oh);
        logic [5:0] b = '0;
        for (int i = 0; i < MSC_N; i++)
            if (oh[i]) b = 6'(i * 8);
        return b;
    endfunction

    // Address counters and synchronous ROMs (1-cycle read latency).
    always @(posedge sysclk) begin
        if (|sel_a) addr_a <= base_of(sel_a);
        else if (add_a) addr_a <= addr_a + 6'd1;
        if (|sel_b) addr_b <= base_of(sel_b);
        else if (add_b) addr_b <= addr_b + 6'd1;
        rom_a <= rom_mem[addr_a];
        rom_b <= rom_mem[addr_b];
    end

    function automatic logic [19:0] pk(input logic [4:0] s, input logic a,
                                       input logic [6:0] n, input logic v,
                                       input logic b, input logic [4:0] id);
        return {s, a, n, v, b, id};
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got sel=%h add=%b note=%h vld=%b busy=%b id=%h, want sel=%h add=%b note=%h vld=%b busy=%b id=%h",
                     nm, act[19:15], act[14], act[13:7], act[6], act[5], act[4:0],
                     exp[19:15], exp[14], exp[13:7], exp[6], exp[5], exp[4:0]);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        play_req = '0; stop = 1'b0; pause = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Expected cycle-by-cycle trace of song s on instance A, expanded from
    // the song contents: LOAD, then per entry FETCH x2, BEAT play cycles
    // (audible for BEAT-GAP if nonzero), one advance cycle.
    task automatic run_song(input int s, input string nm);
        logic [19:0] q[$];
        logic [4:0]  id;
        logic [7:0]  w;
        logic [6:0]  code;
        logic        v;
        int          adds_exp, adds_got;
        id = 5'(1 << s);
        adds_exp = 0;
        adds_got = 0;
        q.push_back(pk(id, 1'b0, 7'd0, 1'b0, 1'b1, id));
        for (int j = 0; j < 8; j++) begin
            q.push_back(pk(5'd0, 1'b0, 7'd0, 1'b0, 1'b1, id));
            q.push_back(pk(5'd0, 1'b0, 7'd0, 1'b0, 1'b1, id));
            w = rom_mem[s * 8 + j];
            if (w == 8'hFF) break;
            code = w[7] ? 7'd0 : w[6:0];
            for (int k = 0; k < BEAT; k++) begin
                v = (k < BEAT - GAP) && (code != 7'd0);
                q.push_back(pk(5'd0, 1'b0, v ? code : 7'd0, v, 1'b1, id));
            end
            q.push_back(pk(5'd0, (j + 1) != MAXN, 7'd0, 1'b0, 1'b1, id));
            if ((j + 1) != MAXN) adds_exp++;
            if ((j + 1) == MAXN) break;
        end
        q.push_back(pk(5'd0, 1'b0, 7'd0, 1'b0, 1'b0, 5'd0));
        q.push_back(pk(5'd0, 1'b0, 7'd0, 1'b0, 1'b0, 5'd0));
        play_req = id;
        tick();
        play_req = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) tick();
            chk(nm, out_a, q[i]);
            adds_got += int'(add_a);
        end
        chk_int({nm, "_adds"}, adds_got, adds_exp);
        $display("song %0d (%s): %0d cycles, %0d add pulses", s, nm, q.size(), adds_got);
    endtask

    typedef struct {
        logic [4:0] req;
        logic [4:0] exp_id;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   adds;
        int   len;

        tbl[0] = '{5'b00100, 5'b00100};
        tbl[1] = '{5'b01010, 5'b00010};
        tbl[2] = '{5'b11000, 5'b01000};
        tbl[3] = '{5'b10000, 5'b10000};
        tbl[4] = '{5'b11111, 5'b00001};
        tbl[5] = '{5'b10100, 5'b00100};

        for (int i = 0; i < 64; i++) rom_mem[i] = 8'hFF;
        for (int i = 0; i < 8; i++) rom_mem[i] = 8'(8'h05 + i);   // song 0: no marker
        rom_mem[8]  = 8'h30; rom_mem[9]  = 8'h00; rom_mem[10] = 8'h85;
        rom_mem[11] = 8'h31; rom_mem[12] = 8'hFF;                 // song 1
        rom_mem[16] = 8'h11; rom_mem[17] = 8'h22; rom_mem[18] = 8'hFF; // song 2
        rom_mem[32] = 8'h40; rom_mem[33] = 8'hFF;                 // song 4

        tick();
        do_reset();
        chk("reset_a", out_a, 20'd0);
        chk("reset_b", out_b, 20'd0);

        // Request encoding: lowest set bit wins.
        for (int i = 0; i < 6; i++) begin
            play_req = tbl[i].req;
            tick();
            play_req = '0;
            chk($sformatf("req_%0d", i), out_a,
                pk(tbl[i].exp_id, 1'b0, 7'd0, 1'b0, 1'b1, tbl[i].exp_id));
            stop = 1'b1;
            tick();
            stop = 1'b0;
            chk($sformatf("req_stop_%0d", i), out_a, 20'd0);
            $display("req %b -> id %b", tbl[i].req, sid_a);
        end

        // Full songs against the expanded trace model.
        run_song(2, "song2");
        run_song(1, "song1_rests");
        run_song(4, "song4");
        run_song(0, "watchdog");

        // Randomized contents for song 3, random idle gaps.
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(0, 5);
            for (int j = 0; j < 8; j++)
                rom_mem[24 + j] = (j == len) ? 8'hFF : 8'($urandom_range(0, 254));
            repeat ($urandom_range(0, 3)) tick();
            run_song(3, $sformatf("rand%0d", t));
        end

        // Pause for 20 cycles at beat count 3 of the first note of song 2.
        do_reset();
        play_req = 5'b00100;
        tick();
        play_req = '0;
        repeat (3) tick();
        chk("pause_first_vld", out_a, pk(5'd0, 1'b0, 7'h11, 1'b1, 1'b1, 5'b00100));
        repeat (3) tick();
        chk("pause_beat3", out_a, pk(5'd0, 1'b0, 7'h11, 1'b1, 1'b1, 5'b00100));
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("paused_%0d", i), out_a, pk(5'd0, 1'b0, 7'd0, 1'b0, 1'b1, 5'b00100));
        end
        pause = 1'b0;
        tick(); chk("resume_b4", out_a, pk(5'd0, 1'b0, 7'h11, 1'b1, 1'b1, 5'b00100));
        tick(); chk("resume_b5", out_a, pk(5'd0, 1'b0, 7'h11, 1'b1, 1'b1, 5'b00100));
        tick(); chk("resume_b6", out_a, pk(5'd0, 1'b0, 7'd0, 1'b0, 1'b1, 5'b00100));
        tick(); chk("resume_b7", out_a, pk(5'd0, 1'b0, 7'd0, 1'b0, 1'b1, 5'b00100));
        tick(); chk("pause_adv", out_a, pk(5'd0, 1'b1, 7'd0, 1'b0, 1'b1, 5'b00100));
        $display("pause sequence: entry took 28 play cycles");

        // Stop beats a simultaneous request.
        do_reset();
        play_req = 5'b00010;
        tick();
        play_req = '0;
        repeat (4) tick();
        stop = 1'b1;
        play_req = 5'b00001;
        tick();
        stop = 1'b0;
        play_req = '0;
        chk("stop_wins", out_a, 20'd0);
        tick();
        chk("stop_no_sel", out_a, 20'd0);

        // Preempt song 1 on its last beat: no add may slip out.
        play_req = 5'b00010;
        tick();
        play_req = '0;
        repeat (10) tick();
        chk("pre_last_beat", out_a, pk(5'd0, 1'b0, 7'd0, 1'b0, 1'b1, 5'b00010));
        play_req = 5'b00001;
        tick();
        play_req = '0;
        chk("preempt_sel", out_a, pk(5'b00001, 1'b0, 7'd0, 1'b0, 1'b1, 5'b00001));
        tick();
        chk("preempt_fetch", out_a, pk(5'd0, 1'b0, 7'd0, 1'b0, 1'b1, 5'b00001));
        $display("stop/preempt sequence done");

        // Reset in the middle of PLAY.
        repeat (3) tick();
        chk("pre_reset_play", out_a, pk(5'd0, 1'b0, 7'h05, 1'b1, 1'b1, 5'b00001));
        rst_n = 1'b0;
        tick();
        chk("reset_mid_a", out_a, 20'd0);
        chk("reset_mid_b", out_b, 20'd0);
        rst_n = 1'b1;

        // Looping instance: marker reloads the song without an add.
        play_req = 5'b00100;
        tick();
        play_req = '0;
        adds = 0;
        for (int c = 0; c < 29; c++) begin
            if (c > 0) tick();
            adds += int'(add_b);
            if (c == 24)
                chk("loop_marker", out_b, pk(5'd0, 1'b0, 7'd0, 1'b0, 1'b1, 5'b00100));
            else if (c == 25)
                chk("loop_reload", out_b, pk(5'b00100, 1'b0, 7'd0, 1'b0, 1'b1, 5'b00100));
            else if (c == 28)
                chk("loop_replay", out_b, pk(5'd0, 1'b0, 7'h11, 1'b1, 1'b1, 5'b00100));
            else
                chk_int($sformatf("loop_busy_%0d", c), int'(busy_b), 1);
        end
        chk_int("loop_adds", adds, 2);
        $display("loop sequence: %0d add pulses before replay", adds);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
